// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the core front end: the data-word width, default
// program-memory depth, the default NOP encoding, the fetch FSM state
// encoding, and the sequential-PC wrap helper.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned DEF_MEM_DEPTH = 256;
  localparam logic [WORD_W-1:0] DEF_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // Sequential successor of a word index. It wraps from depth-1 back to 0.
  // An index that is already out of range also returns 0, so the PC can
  // never walk past the end of memory.
  function automatic logic [WORD_W-1:0] next_pc_wrap(
    input logic [WORD_W-1:0] pc,
    input logic [WORD_W-1:0] depth
  );
    logic [WORD_W-1:0] nxt;
    if (pc >= (depth - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = pc + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Combinational redirect selection for the fetch stage.
//
// Ports
//   pc_i           current program counter (word index)
//   id_pc_plus1_i  id_pc+1 of the instruction held in IF/ID
//   id_valid_i     IF/ID holds a valid instruction
//   jmp_valid_i    absolute jump request
//   jmp_target_i   absolute jump word address
//   br_taken_i     branch taken for the IF/ID instruction
//   br_offset_i    signed word offset relative to id_pc+1
//   redirect_o     a jump, or a branch qualified by id_valid, is active
//   target_o       redirect target (a jump wins over a branch)
//   range_fault_o  an active redirect target is outside memory
//   seq_pc_o       sequential successor of pc_i (wraps at MEM_DEPTH)
// ---------------------------------------------------------------------------
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] id_pc_plus1_i,
  input  logic        id_valid_i,
  input  logic        jmp_valid_i,
  input  logic [31:0] jmp_target_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_offset_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        range_fault_o,
  output logic [31:0] seq_pc_o
);

  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  // Select the redirect source, form its target, and range-check it.
  always_comb begin
    redirect_o = jmp_valid_i | (br_taken_i & id_valid_i);
    if (jmp_valid_i) begin
      target_o = jmp_target_i;
    end else begin
      // Two's-complement add: a negative offset is a plain 32-bit wrap.
      // A result that goes below zero becomes a huge unsigned value,
      // and the range check below catches it.
      target_o = id_pc_plus1_i + br_offset_i;
    end
    range_fault_o = redirect_o & (target_o >= DEPTH_W);
    seq_pc_o      = next_pc_wrap(pc_i, DEPTH_W);
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. It owns the PC, reads a combinational program
// memory, and holds the IF/ID register with a valid/ready handshake toward
// decode. It also applies jump/branch redirects and stalls. A redirect to an
// out-of-range target locks the unit in FAULT until reset.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   imem_pc       word address to program memory (equals PC)
//   imem_data     instruction at imem_pc, same cycle
//   stall         freezes PC and IF/ID unless a redirect is active
//   id_ready      decode accepts id_instr this cycle
//   br_taken      branch taken for the IF/ID instruction
//   br_offset     signed word offset relative to id_pc+1
//   jmp_valid     absolute jump request (has priority over a branch)
//   jmp_target    absolute word address
//   id_valid      IF/ID holds a valid instruction
//   id_instr      latched instruction (NOP_WORD when id_valid=0)
//   id_pc         PC of id_instr
//   id_pc_plus1   id_pc+1 modulo MEM_DEPTH
//   fault         sticky out-of-range redirect indicator
// ---------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] NOP_WORD  = DEF_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus1,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc_plus1_q, id_pc_plus1_d;
  logic         fault_q, fault_d;

  logic         redirect_s;
  logic [31:0]  target_s;
  logic         range_fault_s;
  logic [31:0]  seq_pc_s;

  pc_next_sel #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_pc_next_sel (
    .pc_i          (pc_q),
    .id_pc_plus1_i (id_pc_plus1_q),
    .id_valid_i    (id_valid_q),
    .jmp_valid_i   (jmp_valid),
    .jmp_target_i  (jmp_target),
    .br_taken_i    (br_taken),
    .br_offset_i   (br_offset),
    .redirect_o    (redirect_s),
    .target_o      (target_s),
    .range_fault_o (range_fault_s),
    .seq_pc_o      (seq_pc_s)
  );

  // Next-state and IF/ID update. In RUN the priority is
  // redirect > stall > advance > hold.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus1_d = id_pc_plus1_q;
    fault_d       = fault_q;

    case (state_q)
      BOOT: begin
        // One idle cycle after reset release. Nothing is latched.
        state_d = RUN;
      end
      RUN: begin
        if (redirect_s) begin
          // The word now at imem_data is on the wrong path, so squash it.
          // A redirect is honoured even while stalled.
          id_valid_d = 1'b0;
          id_instr_d = NOP_WORD;
          if (range_fault_s) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = target_s;
          end
        end else if (stall) begin
          pc_d = pc_q;
        end else if (id_ready || !id_valid_q) begin
          id_instr_d    = imem_data;
          id_pc_d       = pc_q;
          id_pc_plus1_d = seq_pc_s;
          id_valid_d    = 1'b1;
          pc_d          = seq_pc_s;
        end else begin
          // Decode has not taken the held instruction yet.
          pc_d = pc_q;
        end
      end
      FAULT: begin
        // Terminal state: all inputs are ignored until reset.
        id_valid_d = 1'b0;
        id_instr_d = NOP_WORD;
        fault_d    = 1'b1;
      end
      default: begin
        // An illegal encoding is treated as a fault so it cannot keep fetching.
        state_d    = FAULT;
        id_valid_d = 1'b0;
        id_instr_d = NOP_WORD;
        fault_d    = 1'b1;
      end
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_WORD;
      id_pc_q       <= 32'd0;
      id_pc_plus1_q <= 32'd0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus1_q <= id_pc_plus1_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_pc     = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus1 = id_pc_plus1_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_data;
  logic        stall = 1'b0;
  logic        id_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = 32'd0;
  logic        jmp_valid = 1'b0;
  logic [31:0] jmp_target = 32'd0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus1;
  logic        fault;

  logic [31:0] mem [0:DEPTH-1];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the architectural state the spec defines.
  int          m_mode;   // 0 boot cycle pending, 1 running, 2 faulted
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc1;
  logic        m_fault;

  always #5 clk = ~clk;

  assign imem_data = (imem_pc < 32'd256) ? mem[imem_pc[7:0]] : 32'hDEAD_BEEF;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_pc     (imem_pc),
    .imem_data   (imem_data),
    .stall       (stall),
    .id_ready    (id_ready),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus1 (id_pc_plus1),
    .fault       (fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("imem_pc",     imem_pc,            m_pc);
    chk("id_valid",    {31'd0, id_valid},  {31'd0, m_valid});
    chk("id_instr",    id_instr,           m_valid ? m_instr : 32'h0000_0000);
    chk("id_pc",       id_pc,              m_idpc);
    chk("id_pc_plus1", id_pc_plus1,        m_idpc1);
    chk("fault",       {31'd0, fault},     {31'd0, m_fault});
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'd0;
    m_valid = 1'b0;
    m_instr = 32'd0;
    m_idpc  = 32'd0;
    m_idpc1 = 32'd0;
    m_fault = 1'b0;
  endtask

  // One clock of spec behaviour, from the inputs currently driven.
  task automatic model_step();
    logic [31:0] tgt;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (jmp_valid || (br_taken && m_valid)) begin
        tgt = jmp_valid ? jmp_target : (m_idpc1 + br_offset);
        m_valid = 1'b0;
        if (tgt >= 32'd256) begin
          m_mode  = 2;
          m_fault = 1'b1;
        end else begin
          m_pc = tgt;
        end
      end else if (!stall && (id_ready || !m_valid)) begin
        m_instr = mem[m_pc[7:0]];
        m_idpc  = m_pc;
        m_idpc1 = (m_pc + 32'd1) % 32'd256;
        m_valid = 1'b1;
        m_pc    = (m_pc + 32'd1) % 32'd256;
      end
    end
  endtask

  // Called at a negedge: drive inputs, advance the model, check at the next negedge.
  task automatic cyc(input logic s, input logic r, input logic b, input logic [31:0] off,
                     input logic j, input logic [31:0] jt);
    stall = s; id_ready = r; br_taken = b; br_offset = off; jmp_valid = j; jmp_target = jt;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0; id_ready = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();
  endtask

  initial begin
    int fault_cycles;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
    end
    model_reset();

    // 1: boot bubble, then sequential fetch 0..4
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("boot_bubble", {31'd0, id_valid}, 32'd0);
    for (int k = 0; k <= 4; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      chk("seq_id_pc", id_pc, 32'(k));
    end
    chk("seq_instr4", id_instr, mem[4]);

    // 2: decode back-pressure holds id_pc 4
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk("hold_id_pc", id_pc, 32'd4);
      chk("hold_imem_pc", imem_pc, 32'd5);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("release_id_pc", id_pc, 32'd5);
    for (int k = 6; k <= 10; k++) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("at_10", id_pc, 32'd10);

    // 3: branch -4 from id_pc 10 -> 7
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
    chk("br_imem_pc", imem_pc, 32'd7);
    chk("br_bubble", {31'd0, id_valid}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("br_id_pc", id_pc, 32'd7);

    // 4: jump beats branch, even under stall
    cyc(1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 32'd20);
    chk("jmp_imem_pc", imem_pc, 32'd20);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("jmp_id_pc", id_pc, 32'd20);

    // 6: wrap at the end of memory
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd250);
    for (int k = 250; k <= 255; k++) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("wrap_id_pc", id_pc, 32'd255);
    chk("wrap_plus1", id_pc_plus1, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("wrap_id_pc0", id_pc, 32'd0);
    chk("wrap_nofault", {31'd0, fault}, 32'd0);

    // 5: out-of-range jump faults; everything frozen until reset
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd300);
    chk("flt_fault", {31'd0, fault}, 32'd1);
    chk("flt_valid", {31'd0, id_valid}, 32'd0);
    chk("flt_pc", imem_pc, 32'd1);
    for (int k = 0; k < 10; k++) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 32'($urandom_range(0, 255)));
      chk("flt_pc_hold", imem_pc, 32'd1);
    end
    do_reset();
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_pc", imem_pc, 32'd0);

    // Random phase
    fault_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        s, r, b, j;
      logic [31:0] off, jt;
      s   = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 15) == 0);
      off = 32'($signed($urandom_range(0, 16)) - 8);
      j   = ($urandom_range(0, 31) == 0);
      jt  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 400))
                                        : 32'($urandom_range(0, 255));
      if (m_mode == 2) fault_cycles++;
      if (fault_cycles > 10 || $urandom_range(0, 299) == 0) begin
        fault_cycles = 0;
        do_reset();
      end else begin
        cyc(s, r, b, off, j, jt);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the single-issue RISC core. It owns the program counter and drives the word address into the combinational program memory. It captures the returned 32-bit instruction into an IF/ID register with a valid/ready handshake toward decode. It applies jump/branch redirects and stalls, and traps out-of-range targets.

Parameters:
MEM_DEPTH, 256, number of 32-bit words in program memory; the PC is a word index in 0..MEM_DEPTH-1.
RESET_PC, 0, first word fetched after reset.
NOP_WORD, 32'h0000_0000, value driven on id_instr whenever id_valid=0.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
imem_pc  out  32  word address to program memory; same-cycle combinational read
imem_data  in  32  instruction word at imem_pc
stall  in  1  hazard stall from decode/execute; freezes PC and IF/ID
id_ready  in  1  decode accepts id_instr this cycle
br_taken  in  1  branch resolved taken this cycle, for the instruction held in IF/ID
br_offset  in  32  signed word offset, relative to id_pc+1
jmp_valid  in  1  absolute jump request
jmp_target  in  32  absolute word address
id_valid  out  1  IF/ID holds a valid instruction
id_instr  out  32  latched instruction
id_pc  out  32  PC of id_instr
id_pc_plus1  out  32  id_pc+1, modulo MEM_DEPTH
fault  out  1  sticky: redirect target out of range

Behaviour:
- Reset (async assert):
  - PC=RESET_PC; id_valid=0; id_instr=NOP_WORD; id_pc=0; id_pc_plus1=0; fault=0; state=BOOT.
- imem_pc equals PC at all times; no memory latency. The instruction at PC is available in the same cycle.
- FSM has three states: BOOT, RUN, FAULT.
  - BOOT: exactly one cycle after rst_n deasserts. Nothing is latched and id_valid stays 0. Next state is RUN.
  - RUN: events are evaluated each cycle in this priority order.
    1. Redirect: jmp_valid, or (br_taken and id_valid). Jump has priority over branch.
       - Target is jmp_target, or id_pc_plus1+br_offset using 32-bit two's-complement arithmetic.
       - If target >= MEM_DEPTH (unsigned): go to FAULT, set fault=1, id_valid<=0, hold PC.
       - Otherwise: PC<=target and id_valid<=0, which squashes the wrong-path word currently at imem_data.
       - Redirect is honoured even when stall=1.
    2. Stall: if stall=1 and there is no redirect, PC and IF/ID hold.
    3. Advance: if id_ready=1 or id_valid=0:
       - id_instr<=imem_data; id_pc<=PC; id_pc_plus1<=PC+1 (mod MEM_DEPTH); id_valid<=1.
       - PC<=PC+1. Sequential increment wraps from MEM_DEPTH-1 to 0 without a fault.
    4. Otherwise (id_valid=1 and id_ready=0): hold.
  - FAULT: terminal until reset. id_valid=0, PC frozen, fault=1. All inputs are ignored.
- id_instr = NOP_WORD whenever id_valid=0.
- Handshake: an instruction transfers on a cycle with id_valid=1, id_ready=1 and no stall. It is never dropped or duplicated except by a redirect squash.
- Throughput is one instruction per cycle in steady state. Redirect penalty is 1 bubble.
- Reset mid-operation takes effect immediately and asynchronously. The first fetch after release is RESET_PC, following the BOOT cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_W=32 and MEM_DEPTH default;
  - NOP_WORD;
  - fetch FSM state encoding (BOOT=2'd0, RUN=2'd1, FAULT=2'd2);
  - helper function next_pc_wrap.
- One natural sub-module, pc_next_sel: a combinational target mux, adder and range check. It outputs the next PC and a range-fault bit.
- The fetch_unit top holds the FSM, PC register and IF/ID register.

Test Plan:
1. Reset, then id_ready=1 constantly, memory loaded 0..7 with distinct words.
   - Expected: BOOT bubble, then id_valid from cycle 2.
   - id_pc = 0,1,2,… and each id_instr matches memory word [id_pc].
2. id_ready=0 for 3 cycles while id_valid=1 holding PC 4.
   - Expected: id_instr/id_pc frozen at 4 and imem_pc stays 5.
   - On id_ready=1, the next transfer is id_pc 5 with no duplicate or drop.
3. Instruction at id_pc=10 with br_taken=1 and br_offset=-4.
   - Expected: next cycle imem_pc=7 and id_valid=0 (1 bubble).
   - The following cycle id_pc=7.
4. jmp_valid=1 (target 20) and br_taken=1 (offset +3) in the same cycle, with stall=1.
   - Expected: jump wins and PC becomes 20 despite the stall.
5. jmp_target=300 with MEM_DEPTH=256.
   - Expected: fault=1 next cycle, id_valid=0, imem_pc held.
   - Outputs stay unchanged for 10 cycles until rst_n pulses low, which clears fault and restarts at RESET_PC.
6. PC reaches 255 with free-running id_ready=1.
   - Expected: next id_pc=0, with id_pc_plus1=0 at id_pc=255.
   - fault stays 0.
